// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

  localparam int BYTE_W      = 8;
  localparam int FRAME_BYTES = 2;
  localparam int CNT_W       = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BYTE_HI = 2'd1,
    BYTE_LO = 2'd2,
    COMMIT  = 2'd3
  } spi_rx_state_e;

  // Assemble the frame value from its two received bytes, first byte high.
  function automatic logic [FRAME_BYTES*BYTE_W-1:0] join_bytes(
    input logic [BYTE_W-1:0] hi,
    input logic [BYTE_W-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input plus rise/fall detect.
// Latency: SYNC_STAGES clk to q; edge pulses coincide with the new q value.
// Backpressure: none; free-running sampler.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   q_d;

  // Shift the raw input through the synchronizer chain and keep one older sample for edge compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      q_d    <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      q_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: receives a two-byte frame into value, returns tx_data on miso.
// Latency: rx_valid 1 clk after the synchronized 8th sclk rise; value_valid 1 clk after that.
// Backpressure: none; outputs are pulses. Optional err_cnt output under SPI_SLAVE_ERR_CNT_EN.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int SCLK_MIN_CLK = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sclk,
  input  logic                          mosi,
  input  logic                          ss_n,
  output logic                          miso,
  input  logic [BYTE_W-1:0]             tx_data,
  output logic [BYTE_W-1:0]             rx_data,
  output logic                          rx_valid,
  output logic [FRAME_BYTES*BYTE_W-1:0] value,
  output logic                          value_valid,
  output logic                          busy
`ifdef SPI_SLAVE_ERR_CNT_EN
  ,
  output logic [7:0]                    err_cnt
`endif
);

  // Edge tracking needs at least a couple of clk samples per sclk half-period.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || SCLK_MIN_CLK < 2) begin : g_param_check
    $error("spi_slave_rx: SYNC_STAGES must be 2..3 and SCLK_MIN_CLK at least 2");
  end

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  logic       sclk_rise, sclk_fall, sclk_s_unused;
  logic       mosi_s;
  logic [1:0] mosi_edges_unused;
  logic       ss_s, ss_fall, ss_rise_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .d    (sclk),
    .q    (sclk_s_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .reset(reset),
    .d    (mosi),
    .q    (mosi_s),
    .rise (mosi_edges_unused[1]),
    .fall (mosi_edges_unused[0])
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk  (clk),
    .reset(reset),
    .d    (ss_n),
    .q    (ss_s),
    .rise (ss_rise_unused),
    .fall (ss_fall)
  );

  spi_rx_state_e     state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] rx_shift;
  logic [BYTE_W-1:0] tx_shift;
  logic [BYTE_W-1:0] hi_byte;
  logic [BYTE_W-1:0] rx_byte;
  logic              in_byte;
  logic              last_edge;
  logic              byte_done;
  logic              load_tx;
  logic              abort;
  logic              commit;

  assign in_byte   = (state == BYTE_HI) || (state == BYTE_LO);
  assign last_edge = sclk_rise && (bit_cnt == LAST_BIT);
  assign rx_byte   = {rx_shift[BYTE_W-2:0], mosi_s};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes; a final sclk edge beats a simultaneous ss_n rise.
  always_comb begin
    state_nxt = state;
    byte_done = 1'b0;
    load_tx   = 1'b0;
    abort     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = BYTE_HI;
          load_tx   = 1'b1;
        end
      end
      BYTE_HI: begin
        if (last_edge) begin
          byte_done = 1'b1;
          if (ss_s) begin
            state_nxt = IDLE;
            abort     = 1'b1;
          end else begin
            state_nxt = BYTE_LO;
            load_tx   = 1'b1;
          end
        end else if (ss_s) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      BYTE_LO: begin
        if (last_edge) begin
          byte_done = 1'b1;
          state_nxt = COMMIT;
        end else if (ss_s) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit counter and receive/transmit shifters; an abort drops any partial byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else if (abort) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
    end else begin
      if (state == IDLE && ss_fall) begin
        bit_cnt <= '0;
      end else if (in_byte && sclk_rise) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= rx_byte;
      end
      // The fall right after a byte boundary (count wrapped to 0) must keep the reloaded MSB on miso.
      if (load_tx) begin
        tx_shift <= tx_data;
      end else if (in_byte && sclk_fall && bit_cnt != '0) begin
        tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
      end
    end
  end

  // Completed bytes, the held high byte and the committed frame value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      hi_byte     <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      rx_valid    <= byte_done;
      value_valid <= commit;
      if (byte_done) begin
        rx_data <= rx_byte;
        if (state == BYTE_HI) hi_byte <= rx_byte;
      end
      if (commit) value <= join_bytes(hi_byte, rx_data);
    end
  end

`ifdef SPI_SLAVE_ERR_CNT_EN
  // Count aborted frames, holding at the top of the range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        err_cnt <= '0;
    else if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

  assign busy = (state != IDLE);
  assign miso = (state != IDLE && !ss_s) ? tx_shift[BYTE_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx with a scoreboard monitor on rx_valid/value_valid.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_spi_slave_rx;

  localparam int HALF = 4;  // clk cycles per sclk half-period (sclk = clk/8)

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss_n = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        miso;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] value;
  logic        value_valid;
  logic        busy;
`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_err = 0;
  logic [7:0]  exp_rx[$];
  logic [15:0] exp_val[$];
  logic [15:0] cap;

  always #5 clk = ~clk;

  spi_slave_rx #(.SYNC_STAGES(2), .SCLK_MIN_CLK(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .mosi       (mosi),
    .ss_n       (ss_n),
    .miso       (miso),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .value      (value),
    .value_valid(value_valid),
    .busy       (busy)
`ifdef SPI_SLAVE_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL rx_unexpected: got rx_data 0x%0h, expected no pulse", rx_data);
      end else begin
        check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
      end
    end
    if (value_valid) begin
      if (exp_val.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL value_unexpected: got value 0x%0h, expected no pulse", value);
      end else begin
        check("value", {16'h0, value}, {16'h0, exp_val.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame();
    ss_n = 1'b0;
    tick(HALF);
  endtask

  task automatic shift_bits(input logic [15:0] d, input int nbits, output logic [15:0] c);
    c = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[15-i];
      tick(HALF);
      c = {c[14:0], miso};
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    tick(HALF);
    ss_n = 1'b1;
    mosi = 1'b0;
    tick(2 * HALF);
  endtask

  task automatic full_frame(input logic [15:0] d, output logic [15:0] c);
    start_frame();
    shift_bits(d, 16, c);
    end_frame();
  endtask

  task automatic check_err();
`ifdef SPI_SLAVE_ERR_CNT_EN
    check("err_cnt", {24'h0, err_cnt}, exp_err);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    tick(3);
    check("reset busy", {31'h0, busy}, 0);
    check("reset value", {16'h0, value}, 0);
    check("reset rx_data", {24'h0, rx_data}, 0);
    check("reset miso", {31'h0, miso}, 0);
    reset = 1'b1;
    tick(4);

    // Basic frame 0x12, 0x34.
    tx_data = 8'h00;
    exp_rx.push_back(8'h12); exp_rx.push_back(8'h34); exp_val.push_back(16'h1234);
    full_frame(16'h1234, cap);
    check("value after 1234", {16'h0, value}, 16'h1234);
    check("idle busy", {31'h0, busy}, 0);
    check("idle miso", {31'h0, miso}, 0);

    // Abort after 11 bits: first byte completes, value untouched.
    exp_rx.push_back(8'hFF);
    start_frame();
    shift_bits(16'hFFFF, 11, cap);
    end_frame();
    exp_err = 1;
    check("value after abort", {16'h0, value}, 16'h1234);
    check("busy after abort", {31'h0, busy}, 0);
    check_err();

    // tx_data returned on miso for both bytes.
    tx_data = 8'hA5;
    exp_rx.push_back(8'h3C); exp_rx.push_back(8'h5A); exp_val.push_back(16'h3C5A);
    full_frame(16'h3C5A, cap);
    check("miso capture", {16'h0, cap}, 16'hA5A5);
    check("value after 3C5A", {16'h0, value}, 16'h3C5A);

    // Reset mid-frame after 5 bits.
    tx_data = 8'h00;
    start_frame();
    shift_bits(16'hAAAA, 5, cap);
    reset = 1'b0;
    #1;
    check("busy in reset", {31'h0, busy}, 0);
    check("rx_valid in reset", {31'h0, rx_valid}, 0);
    check("value_valid in reset", {31'h0, value_valid}, 0);
    check("value in reset", {16'h0, value}, 0);
    check("miso in reset", {31'h0, miso}, 0);
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tick(3);
    reset = 1'b1;
    exp_err = 0;
    tick(4);
    check_err();
    exp_rx.push_back(8'h00); exp_rx.push_back(8'h07); exp_val.push_back(16'h0007);
    full_frame(16'h0007, cap);
    check("value after 0007", {16'h0, value}, 16'h0007);

    // Frame followed by extra sclk pulses while still selected.
    exp_rx.push_back(8'hBE); exp_rx.push_back(8'hEF); exp_val.push_back(16'hBEEF);
    start_frame();
    shift_bits(16'hBEEF, 16, cap);
    shift_bits(16'hFFFF, 4, cap);
    end_frame();
    check("value after BEEF", {16'h0, value}, 16'hBEEF);
    check("busy after extra edges", {31'h0, busy}, 0);

    // ss_n rise on the same clk as the final sclk rise still commits.
    exp_rx.push_back(8'h55); exp_rx.push_back(8'hAA); exp_val.push_back(16'h55AA);
    start_frame();
    shift_bits(16'h55AA, 15, cap);
    mosi = 1'b0;
    tick(HALF);
    sclk = 1'b1;
    ss_n = 1'b1;
    tick(HALF);
    sclk = 1'b0;
    tick(2 * HALF);
    check("value after edge-win", {16'h0, value}, 16'h55AA);

    // 256 aborted frames saturate the error counter.
    for (int k = 0; k < 256; k++) begin
      ss_n = 1'b0;
      tick(HALF);
      ss_n = 1'b1;
      tick(HALF);
      if (exp_err < 255) exp_err++;
    end
    tick(4);
    check_err();
    check("value after aborts", {16'h0, value}, 16'h55AA);
    check("busy after aborts", {31'h0, busy}, 0);

    tick(4);
    check("rx queue drained", exp_rx.size(), 0);
    check("value queue drained", exp_val.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
